pb_board_responder: RTL and testbench

- Board-side responder for the lamp/ADC parallel bus driven by the host command state machines.
- Decodes board select (BOARD_X), port address (AddessPort) and the active-low strobes (PB_RD, PB_WR).
- Latches host writes into a small register file, drives read data back, and answers test-address cycles with a board ID.
- Emulates one ADC conversion channel.
- Used as a bench model for the host block and as the FPGA image of a single lamp board.

---
 rtl/pb_board_responder.sv | 249 ++++++++++++++++++++++++
 tb/tb_pb_board_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_board_responder.sv
// Board-side responder for the lamp/ADC parallel bus: register file, read-back, board ID and one ADC channel.
// Optional build macro PB_RESP_LAMP_RESET_EN adds the active-low LampResetPin input.
module pb_board_responder #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BOARD_BIT       = 0,
  parameter int RD_DRIVE_DELAY  = 2,
  parameter int ADC_CONV_CYCLES = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] BOARD_X,
  input  logic [2:0] AddessPort,
  input  logic       TestAddress,
  input  logic       PB_RD,
  input  logic       PB_WR,
  input  logic [7:0] Data_In_Port,
`ifdef PB_RESP_LAMP_RESET_EN
  input  logic       LampResetPin,
`endif
  output logic [7:0] Data_Out_Port,
  output logic       data_oe,
  input  logic [7:0] adc_sample,
  output logic [7:0] lamp_out,
  output logic       write_strobe,
  output logic [2:0] wr_port,
  output logic [7:0] wr_data
);

  if (CLOCK_FREQUENCY <= 0 || BOARD_BIT < 0 || BOARD_BIT > 3 || RD_DRIVE_DELAY < 1 ||
      RD_DRIVE_DELAY > 7 || ADC_CONV_CYCLES < 1 || ADC_CONV_CYCLES > 255) begin : g_bad_param
    $error("pb_board_responder: parameter out of range");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_TEST  = 2'd3;
  localparam logic [1:0] A_IDLE   = 2'd0;
  localparam logic [1:0] A_BUSY   = 2'd1;
  localparam logic [1:0] A_DONE   = 2'd2;
  localparam logic [7:0] TEST_ID   = 8'hA0 | 8'(BOARD_BIT);
  localparam logic [2:0] DRIVE_DLY = 3'(RD_DRIVE_DELAY);
  localparam logic [7:0] CONV_LEN  = 8'(ADC_CONV_CYCLES);
  localparam logic [3:0] RSEL_CODE = 4'b0001 << BOARD_BIT;

`ifdef PB_RESP_LAMP_RESET_EN
  localparam int SYNC_W = 19;
  localparam logic [SYNC_W-1:0] SYNC_RST = {1'b1, 18'd0};
  logic [SYNC_W-1:0] raw_w;
  assign raw_w = {LampResetPin, BOARD_X, AddessPort, TestAddress, PB_RD, PB_WR, Data_In_Port};
`else
  localparam int SYNC_W = 18;
  localparam logic [SYNC_W-1:0] SYNC_RST = 18'd0;
  logic [SYNC_W-1:0] raw_w;
  assign raw_w = {BOARD_X, AddessPort, TestAddress, PB_RD, PB_WR, Data_In_Port};
`endif

  logic [SYNC_W-1:0] sync1_q, sync2_q;
  logic [3:0]        s_board_x;
  logic [2:0]        s_addr;
  logic [7:0]        s_data;
  logic              s_test, s_rd, s_wr, s_lamp_rst_n;
  logic              wsel, rsel, commit, rd_exit4, busy_d, rt_sel;
  logic [1:0]        bus_q, bus_d, adc_q, adc_d;
  logic              armed_q, armed_d;
  logic [2:0]        cap_port_q, cap_port_d, rd_port_q, rd_port_d;
  logic [7:0]        cap_data_q, cap_data_d;
  logic [3:0][7:0]   regs_q, regs_d;
  logic [7:0]        cnt_q, cnt_d, result_q, result_d;
  logic              done_q, done_d;
  logic [2:0]        dly_q, dly_d;
  logic              oe_q, oe_d, ws_q;
  logic [7:0]        dout_q, dout_d, wr_data_q, wr_data_d;
  logic [2:0]        wr_port_q, wr_port_d;

  assign s_data    = sync2_q[7:0];
  assign s_wr      = sync2_q[8];
  assign s_rd      = sync2_q[9];
  assign s_test    = sync2_q[10];
  assign s_addr    = sync2_q[13:11];
  assign s_board_x = sync2_q[17:14];
`ifdef PB_RESP_LAMP_RESET_EN
  assign s_lamp_rst_n = sync2_q[18];
`else
  assign s_lamp_rst_n = 1'b1;
`endif

  assign wsel = s_board_x[BOARD_BIT];
  assign rsel = (s_board_x == RSEL_CODE);

  function automatic logic [7:0] port_data(input logic [2:0] port, input logic [3:0][7:0] regs,
                                           input logic [7:0] result, input logic busy, input logic done);
    logic [7:0] v;
    case (port)
      3'd0, 3'd1, 3'd2, 3'd3: v = regs[port[1:0]];
      3'd4:    v = result;
      3'd5:    v = {busy, 6'b000000, done};
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Bus cycle decode; no cycle is accepted after reset until both strobes have read high.
  always_comb begin
    armed_d = armed_q | (s_rd & s_wr);
    bus_d   = ST_IDLE;
    if (armed_q) begin
      case ({s_rd, s_wr})
        2'b10:   bus_d = wsel ? ST_WRITE : ST_IDLE;
        2'b01:   bus_d = rsel ? ST_READ : ST_IDLE;
        2'b00:   bus_d = (s_test && rsel) ? ST_TEST : ST_IDLE;
        default: bus_d = ST_IDLE;
      endcase
    end else begin
      bus_d = ST_IDLE;
    end
    commit     = (bus_q == ST_WRITE) && s_rd && s_wr && s_lamp_rst_n;
    rd_exit4   = (bus_q == ST_READ) && (bus_d != ST_READ) && (rd_port_q == 3'd4);
    cap_port_d = (bus_d == ST_WRITE) ? s_addr : cap_port_q;
    cap_data_d = (bus_d == ST_WRITE) ? s_data : cap_data_q;
    rd_port_d  = (bus_d == ST_READ) ? s_addr : rd_port_q;
  end

  // Write commit into the register file and the last-write report.
  always_comb begin
    regs_d    = regs_q;
    wr_port_d = wr_port_q;
    wr_data_d = wr_data_q;
    if (commit) begin
      wr_port_d = cap_port_q;
      wr_data_d = cap_data_q;
      if (!cap_port_q[2]) begin
        regs_d[cap_port_q[1:0]] = cap_data_q;
      end else begin
        regs_d = regs_q;
      end
    end else begin
      wr_port_d = wr_port_q;
    end
    if (!s_lamp_rst_n) begin
      regs_d = {4{8'h00}};
    end else begin
      wr_data_d = wr_data_d;
    end
  end

  // ADC emulation: a port-4 write starts a conversion unless one is already running.
  always_comb begin
    adc_d    = adc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    case (adc_q)
      A_BUSY: begin
        if (cnt_q == 8'd1) begin
          adc_d  = A_DONE;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      A_IDLE, A_DONE: begin
        if (commit && (cap_port_q == 3'd4)) begin
          adc_d    = A_BUSY;
          cnt_d    = CONV_LEN;
          result_d = adc_sample;
          done_d   = 1'b0;
        end else if (rd_exit4) begin
          done_d = 1'b0;
        end else begin
          done_d = done_q;
        end
      end
      default: adc_d = A_IDLE;
    endcase
    busy_d = (adc_d == A_BUSY);
  end

  // Read/test drive: output enable after the drive delay, data tracks the current port.
  always_comb begin
    rt_sel = (bus_d == ST_READ) || (bus_d == ST_TEST);
    if (!rt_sel) begin
      dly_d = 3'd0;
    end else if (bus_d != bus_q) begin
      dly_d = 3'd1;
    end else if (dly_q != 3'd7) begin
      dly_d = dly_q + 3'd1;
    end else begin
      dly_d = dly_q;
    end
    oe_d = rt_sel && (dly_d >= DRIVE_DLY);
    case (bus_d)
      ST_READ: dout_d = port_data(s_addr, regs_q, result_d, busy_d, done_d);
      ST_TEST: dout_d = TEST_ID;
      default: dout_d = dout_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q    <= SYNC_RST;
      sync2_q    <= SYNC_RST;
      bus_q      <= ST_IDLE;
      armed_q    <= 1'b0;
      cap_port_q <= 3'd0;
      cap_data_q <= 8'h00;
      rd_port_q  <= 3'd0;
      regs_q     <= {4{8'h00}};
      adc_q      <= A_IDLE;
      cnt_q      <= 8'd0;
      result_q   <= 8'h00;
      done_q     <= 1'b0;
      dly_q      <= 3'd0;
      oe_q       <= 1'b0;
      dout_q     <= 8'h00;
      ws_q       <= 1'b0;
      wr_port_q  <= 3'd0;
      wr_data_q  <= 8'h00;
    end else begin
      sync1_q    <= raw_w;
      sync2_q    <= sync1_q;
      bus_q      <= bus_d;
      armed_q    <= armed_d;
      cap_port_q <= cap_port_d;
      cap_data_q <= cap_data_d;
      rd_port_q  <= rd_port_d;
      regs_q     <= regs_d;
      adc_q      <= adc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      done_q     <= done_d;
      dly_q      <= dly_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      ws_q       <= commit;
      wr_port_q  <= wr_port_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign Data_Out_Port = dout_q;
  assign data_oe       = oe_q;
  assign lamp_out      = regs_q[0];
  assign write_strobe  = ws_q;
  assign wr_port       = wr_port_q;
  assign wr_data       = wr_data_q;

endmodule

// File: tb/tb_pb_board_responder.sv
// Bench for pb_board_responder: two boards (BOARD_BIT 0 and 2) on one bus, checked
// against a transaction-level model of registers, ADC result/done and bus timing.
module tb_pb_board_responder;
  localparam int D    = 2;   // RD_DRIVE_DELAY
  localparam int N    = 27;  // ADC_CONV_CYCLES
  localparam int SYNC = 2;   // input synchroniser depth

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, ta, rd_n, wr_n;
  logic [3:0] bx;
  logic [2:0] port;
  logic [7:0] din, adc_in;
  logic [7:0] dout0, dout2, lamp0, lamp2, wrd0, wrd2;
  logic       oe0, oe2, ws0, ws2;
  logic [2:0] wrp0, wrp2;

  pb_board_responder #(.BOARD_BIT(0), .RD_DRIVE_DELAY(D), .ADC_CONV_CYCLES(N)) u_b0 (
    .clock(clock), .reset(reset), .BOARD_X(bx), .AddessPort(port), .TestAddress(ta),
    .PB_RD(rd_n), .PB_WR(wr_n), .Data_In_Port(din),
`ifdef PB_RESP_LAMP_RESET_EN
    .LampResetPin(1'b1),
`endif
    .Data_Out_Port(dout0), .data_oe(oe0), .adc_sample(adc_in), .lamp_out(lamp0),
    .write_strobe(ws0), .wr_port(wrp0), .wr_data(wrd0));

  pb_board_responder #(.BOARD_BIT(2), .RD_DRIVE_DELAY(D), .ADC_CONV_CYCLES(N)) u_b2 (
    .clock(clock), .reset(reset), .BOARD_X(bx), .AddessPort(port), .TestAddress(ta),
    .PB_RD(rd_n), .PB_WR(wr_n), .Data_In_Port(din),
`ifdef PB_RESP_LAMP_RESET_EN
    .LampResetPin(1'b1),
`endif
    .Data_Out_Port(dout2), .data_oe(oe2), .adc_sample(adc_in), .lamp_out(lamp2),
    .write_strobe(ws2), .wr_port(wrp2), .wr_data(wrd2));

  int cyc = 0;
  int ws_cnt0 = 0, ws_cnt2 = 0, ws_last0 = -1, ws_last2 = -1;
  int n_checks = 0, n_fail = 0;
  int last_commit = 0;
  logic [7:0] m_regs [2][4];
  logic [7:0] m_result [2];
  logic       m_done [2];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (ws0) begin ws_cnt0 = ws_cnt0 + 1; ws_last0 = cyc; end
    if (ws2) begin ws_cnt2 = ws_cnt2 + 1; ws_last2 = cyc; end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic at_neg(input int k);
    @(negedge clock);
    while (cyc < k) @(negedge clock);
  endtask

  function automatic logic [7:0] model_data(input int b, input logic [2:0] p);
    if (p < 3'd4) return m_regs[b][p[1:0]];
    else if (p == 3'd4) return m_result[b];
    else if (p == 3'd5) return {7'd0, m_done[b]};
    else return 8'h00;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 4; p++) m_regs[b][p] = 8'h00;
      m_result[b] = 8'h00;
      m_done[b]   = 1'b0;
    end
  endtask

  task automatic do_write(input logic [3:0] bx_v, input logic [2:0] port_v, input logic [7:0] data_v);
    int c0, c2, rel;
    c0 = ws_cnt0; c2 = ws_cnt2;
    tick(1); bx = bx_v; port = port_v; din = data_v; ta = 1'b0; wr_n = 1'b0;
    tick(4); wr_n = 1'b1; rel = cyc;
    tick(5);
    last_commit = rel + 1 + SYNC;
    check_eq("wr_count0", ws_cnt0 - c0, {31'd0, bx_v[0]});
    check_eq("wr_count2", ws_cnt2 - c2, {31'd0, bx_v[2]});
    if (bx_v[0]) begin
      check_eq("wr_time0", ws_last0, last_commit);
      check_eq("wr_port0", wrp0, port_v);
      check_eq("wr_data0", wrd0, data_v);
      if (port_v < 3'd4) m_regs[0][port_v[1:0]] = data_v;
      if (port_v == 3'd4) begin m_result[0] = adc_in; m_done[0] = 1'b0; end
    end
    if (bx_v[2]) begin
      check_eq("wr_port2", wrp2, port_v);
      check_eq("wr_data2", wrd2, data_v);
      if (port_v < 3'd4) m_regs[1][port_v[1:0]] = data_v;
      if (port_v == 3'd4) begin m_result[1] = adc_in; m_done[1] = 1'b0; end
    end
    check_eq("lamp0", lamp0, m_regs[0][0]);
    check_eq("lamp2", lamp2, m_regs[1][0]);
  endtask

  task automatic do_read(input logic [3:0] bx_v, input logic [2:0] port_v);
    int st, rel;
    logic drv0, drv2;
    drv0 = (bx_v == 4'h1);
    drv2 = (bx_v == 4'h4);
    tick(1); bx = bx_v; port = port_v; ta = 1'b0; rd_n = 1'b0; st = cyc;
    at_neg(st + SYNC + D - 1);
    check_eq("rd_oe_early0", oe0, 1'b0);
    check_eq("rd_oe_early2", oe2, 1'b0);
    at_neg(st + SYNC + D);
    check_eq("rd_oe0", oe0, drv0);
    check_eq("rd_oe2", oe2, drv2);
    if (drv0) check_eq("rd_data0", dout0, model_data(0, port_v));
    if (drv2) check_eq("rd_data2", dout2, model_data(1, port_v));
    tick(1); rd_n = 1'b1; rel = cyc;
    at_neg(rel + SYNC);
    check_eq("rd_oe_hold0", oe0, drv0);
    at_neg(rel + SYNC + 1);
    check_eq("rd_oe_off0", oe0, 1'b0);
    check_eq("rd_oe_off2", oe2, 1'b0);
    if (drv0 && port_v == 3'd4) m_done[0] = 1'b0;
    if (drv2 && port_v == 3'd4) m_done[1] = 1'b0;
    tick(1);
  endtask

  logic [3:0] bx_tab [5] = '{4'h1, 4'h2, 4'h4, 4'hF, 4'h0};

  initial begin
    int st, rel, c0, r;
    logic [3:0] rbx;
    logic [2:0] rport;
    reset = 1'b0; bx = 4'h0; port = 3'd0; ta = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    din = 8'h00; adc_in = 8'h00;
    model_reset();
    tick(3);
    at_neg(cyc + 1);
    check_eq("rst_oe0", oe0, 1'b0);
    check_eq("rst_dout0", dout0, 8'h00);
    check_eq("rst_lamp0", lamp0, 8'h00);
    check_eq("rst_ws0", ws0, 1'b0);
    check_eq("rst_wrport0", wrp0, 3'd0);
    check_eq("rst_wrdata0", wrd0, 8'h00);
    tick(1); reset = 1'b1;
    tick(4);

    // Directed writes and reads.
    do_write(4'h1, 3'd0, 8'h5A);
    do_write(4'h2, 3'd0, 8'h33);
    do_write(4'h1, 3'd2, 8'h3C);
    do_read(4'h1, 3'd2);
    do_write(4'hF, 3'd1, 8'h11);
    do_read(4'hF, 3'd1);
    do_read(4'h1, 3'd1);
    do_read(4'h4, 3'd1);

    // ADC conversion, watched continuously on port 5 across the done boundary.
    adc_in = 8'h77;
    do_write(4'h1, 3'd4, 8'hC3);
    tick(1); bx = 4'h1; port = 3'd5; rd_n = 1'b0; st = cyc;
    for (int k = st + SYNC + 1; k <= last_commit + N + 2; k++) begin
      at_neg(k);
      check_eq("adc_status", dout0, (k >= last_commit + N) ? 8'h01 : 8'h80);
      check_eq("adc_oe", oe0, (k >= st + SYNC + D) ? 1'b1 : 1'b0);
    end
    tick(1); rd_n = 1'b1;
    tick(4);
    m_done[0] = 1'b1;
    do_read(4'h1, 3'd4);
    do_read(4'h1, 3'd5);
    do_read(4'h4, 3'd5);

    // Test-address cycle for board 2.
    tick(1); bx = 4'h4; port = 3'd0; ta = 1'b1; rd_n = 1'b0; wr_n = 1'b0; st = cyc;
    at_neg(st + SYNC + D - 1);
    check_eq("test_oe_early2", oe2, 1'b0);
    at_neg(st + SYNC + D);
    check_eq("test_oe2", oe2, 1'b1);
    check_eq("test_id2", dout2, 8'hA2);
    check_eq("test_oe0", oe0, 1'b0);
    tick(1); rd_n = 1'b1; wr_n = 1'b1; ta = 1'b0; rel = cyc;
    at_neg(rel + SYNC + 1);
    check_eq("test_oe_off2", oe2, 1'b0);

    // Write abandoned by a test cycle: no strobe, no storage.
    c0 = ws_cnt0;
    tick(1); bx = 4'h1; port = 3'd3; din = 8'hEE; ta = 1'b1; wr_n = 1'b0;
    tick(4); rd_n = 1'b0; st = cyc;
    at_neg(st + SYNC + D);
    check_eq("abort_test_oe0", oe0, 1'b1);
    check_eq("abort_test_id0", dout0, 8'hA0);
    tick(1); rd_n = 1'b1; wr_n = 1'b1; ta = 1'b0;
    tick(6);
    check_eq("abort_no_strobe", ws_cnt0 - c0, 0);
    do_read(4'h1, 3'd3);

    // Randomised traffic against the model (no ADC starts).
    for (int i = 0; i < 40; i++) begin
      rbx = bx_tab[$urandom_range(0, 4)];
      if (rbx == 4'h0) rbx = 4'($urandom_range(0, 15));
      rport = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        if (rport == 3'd4) rport = 3'd5;
        do_write(rbx, rport, 8'($urandom_range(0, 255)));
      end else begin
        do_read(rbx, rport);
      end
    end

    // Reset in the middle of a driven read.
    do_write(4'h5, 3'd0, 8'hA5);
    tick(1); bx = 4'h1; port = 3'd0; rd_n = 1'b0; st = cyc;
    at_neg(st + SYNC + D);
    check_eq("pre_reset_oe0", oe0, 1'b1);
    tick(1); reset = 1'b0; r = cyc;
    at_neg(r + 1);
    check_eq("reset_oe0", oe0, 1'b0);
    check_eq("reset_lamp0", lamp0, 8'h00);
    check_eq("reset_lamp2", lamp2, 8'h00);
    check_eq("reset_wrport0", wrp0, 3'd0);
    check_eq("reset_wrdata0", wrd0, 8'h00);
    tick(2); reset = 1'b1; r = cyc;
    for (int k = r + 1; k <= r + 8; k++) begin
      at_neg(k);
      check_eq("post_reset_no_cycle", oe0, 1'b0);
    end
    tick(1); rd_n = 1'b1;
    tick(4);
    model_reset();
    do_read(4'h1, 3'd0);
    do_read(4'h1, 3'd4);
    do_read(4'h4, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
